// File: rtl/board_tile_reader.sv
// Display-side reader: snapshots the 16-tile board each frame into a 4-bit exponent bank
// and colours pixels through a 2-stage pipeline. Optional feature macro: DONE_BLINK_EN.
module board_tile_reader #(
    parameter int BOARD_X0   = 192,
    parameter int BOARD_Y0   = 112,
    parameter int TILE_SHIFT = 6,
    parameter int GAP        = 4
) (
    input  logic         SymClk,
    input  logic         Reset,
    input  logic [191:0] MatrixCopy,
    input  logic         Done,
    input  logic         frame_start,
    input  logic         pix_valid,
    input  logic [9:0]   pix_x,
    input  logic [9:0]   pix_y,
    output logic         rgb_valid,
    output logic         vga_r,
    output logic         vga_g,
    output logic         vga_b,
    output logic         scan_busy,
    output logic         bad_tile
);

    localparam logic signed [10:0]   X0_S   = 11'(BOARD_X0);
    localparam logic signed [10:0]   Y0_S   = 11'(BOARD_Y0);
    localparam logic signed [10:0]   SPAN_S = 11'(4 << TILE_SHIFT);
    localparam logic [TILE_SHIFT-1:0] GAP_L = TILE_SHIFT'(GAP);

    typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;

    state_t           state, state_nxt;
    logic [3:0]       tile_cnt;
    logic [191:0]     shadow;
    logic             disp_bank;
    logic [15:0][3:0] bank0, bank1;
    logic             scan_we;
    logic [11:0]      cur_tile;
    logic [3:0]       cur_exp;
    logic             blink;

    // Zero, an exact power of two 2..2048, or anything else (flagged as 15).
    function automatic logic [3:0] tile_exp(input logic [11:0] v);
        logic [3:0] e;
        e = 4'd15;
        if (v == 12'd0) begin
            e = 4'd0;
        end else begin
            for (int k = 1; k < 12; k++) begin
                if (v == (12'd1 << k)) e = 4'(k);
            end
        end
        return e;
    endfunction

    function automatic logic [2:0] exp_colour(input logic [3:0] e);
        logic [2:0] c;
        case (e)
            4'd0:    c = 3'b001;
            4'd1:    c = 3'b010;
            4'd2:    c = 3'b011;
            4'd3:    c = 3'b100;
            4'd4:    c = 3'b101;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: c = 3'b110;
            default: c = 3'b111;
        endcase
        return c;
    endfunction

    always_ff @(posedge SymClk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = SCAN;
            SCAN:    if (tile_cnt == 4'd15) state_nxt = SWAP;
            SWAP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        scan_busy = (state == SCAN);
        scan_we   = (state == SCAN);
    end

    always_ff @(posedge SymClk or posedge Reset) begin
        if (Reset) begin
            shadow   <= '0;
            tile_cnt <= '0;
        end else if (state == IDLE && frame_start) begin
            shadow   <= MatrixCopy;
            tile_cnt <= '0;
        end else if (scan_we) begin
            tile_cnt <= tile_cnt + 4'd1;
        end
    end

    assign cur_tile = shadow[int'(tile_cnt) * 12 +: 12];
    assign cur_exp  = tile_exp(cur_tile);

    // Scan results land in the bank not on display; the swap flips which one is shown.
    always_ff @(posedge SymClk or posedge Reset) begin
        if (Reset) begin
            bank0     <= '0;
            bank1     <= '0;
            disp_bank <= 1'b0;
            bad_tile  <= 1'b0;
        end else begin
            if (scan_we) begin
                if (disp_bank) bank0[tile_cnt] <= cur_exp;
                else           bank1[tile_cnt] <= cur_exp;
                if (cur_exp == 4'd15) bad_tile <= 1'b1;
            end
            if (state == SWAP) disp_bank <= ~disp_bank;
        end
    end

`ifdef DONE_BLINK_EN
    logic [4:0] frame_cnt;

    always_ff @(posedge SymClk or posedge Reset) begin
        if (Reset)            frame_cnt <= '0;
        else if (frame_start) frame_cnt <= frame_cnt + 5'd1;
    end

    assign blink = Done && frame_cnt[4];
`else
    logic unused_done;

    assign unused_done = Done;
    assign blink       = 1'b0;
`endif

    logic signed [10:0] lx_p0, ly_p0;
    logic               in_board_p0, gap_p0;
    logic [3:0]         tile_p0;

    assign lx_p0       = $signed({1'b0, pix_x}) - X0_S;
    assign ly_p0       = $signed({1'b0, pix_y}) - Y0_S;
    assign in_board_p0 = !lx_p0[10] && (lx_p0 < SPAN_S) && !ly_p0[10] && (ly_p0 < SPAN_S);
    assign gap_p0      = (lx_p0[TILE_SHIFT-1:0] < GAP_L) || (ly_p0[TILE_SHIFT-1:0] < GAP_L);
    assign tile_p0     = {ly_p0[TILE_SHIFT+1:TILE_SHIFT], lx_p0[TILE_SHIFT+1:TILE_SHIFT]};

    // S1 boundary: board-relative geometry registered.
    logic       vld_p1, in_board_p1, gap_p1;
    logic [3:0] tile_p1;

    always_ff @(posedge SymClk or posedge Reset) begin
        if (Reset) vld_p1 <= 1'b0;
        else       vld_p1 <= pix_valid;
    end

    always_ff @(posedge SymClk) begin
        in_board_p1 <= in_board_p0;
        gap_p1      <= gap_p0;
        tile_p1     <= tile_p0;
    end

    logic [3:0] exp_p1;
    logic [2:0] rgb_p1;

    assign exp_p1 = disp_bank ? bank1[tile_p1] : bank0[tile_p1];

    always_comb begin
        rgb_p1 = 3'b000;
        if (vld_p1 && in_board_p1) begin
            rgb_p1 = gap_p1 ? 3'b000 : exp_colour(exp_p1);
            if (blink) rgb_p1 = rgb_p1 ^ 3'b111;
        end
    end

    // S2 boundary: colour registered to the outputs.
    logic       vld_p2;
    logic [2:0] rgb_p2;

    always_ff @(posedge SymClk or posedge Reset) begin
        if (Reset) begin
            vld_p2 <= 1'b0;
            rgb_p2 <= 3'b000;
        end else begin
            vld_p2 <= vld_p1;
            rgb_p2 <= rgb_p1;
        end
    end

    assign rgb_valid = vld_p2;
    assign vga_r     = rgb_p2[2];
    assign vga_g     = rgb_p2[1];
    assign vga_b     = rgb_p2[0];

endmodule

// File: tb/tb_board_tile_reader.sv
// Scoreboard bench for board_tile_reader; honours DONE_BLINK_EN when defined.
module tb_board_tile_reader;

    logic         SymClk = 1'b0;
    logic         Reset;
    logic [191:0] MatrixCopy;
    logic         Done;
    logic         frame_start;
    logic         pix_valid;
    logic [9:0]   pix_x, pix_y;
    logic         rgb_valid, vga_r, vga_g, vga_b, scan_busy, bad_tile;

    board_tile_reader dut (
        .SymClk      (SymClk),
        .Reset       (Reset),
        .MatrixCopy  (MatrixCopy),
        .Done        (Done),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .rgb_valid   (rgb_valid),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .scan_busy   (scan_busy),
        .bad_tile    (bad_tile)
    );

    always #5 SymClk = ~SymClk;

    typedef struct {
        logic [2:0] rgb;
        int         due;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           shown[16];
    int           fcnt = 0;
    logic         bad_m = 1'b0;
    logic [191:0] brd;

    always @(posedge SymClk) cyc <= cyc + 1;

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int calc_exp(int v);
        if (v == 0) return 0;
        for (int e = 1; e <= 11; e++) if (v == (1 << e)) return e;
        return 15;
    endfunction

    function automatic logic [2:0] exp_rgb(int e);
        if (e == 0) return 3'b001;
        if (e == 1) return 3'b010;
        if (e == 2) return 3'b011;
        if (e == 3) return 3'b100;
        if (e == 4) return 3'b101;
        if (e >= 5 && e <= 11) return 3'b110;
        return 3'b111;
    endfunction

    function automatic logic [2:0] model_rgb(int x, int y);
        int lx = x - 192;
        int ly = y - 112;
        logic [2:0] c;
        if (lx < 0 || ly < 0 || lx >= 256 || ly >= 256) return 3'b000;
        if ((lx % 64) < 4 || (ly % 64) < 4) c = 3'b000;
        else c = exp_rgb(shown[(ly / 64) * 4 + lx / 64]);
`ifdef DONE_BLINK_EN
        if (Done && (fcnt % 32) >= 16) c = ~c;
`endif
        return c;
    endfunction

    always @(negedge SymClk) begin
        if (!Reset) begin
            if (rgb_valid) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("pix_latency", cyc, mon_e.due);
                    check_val("pix_rgb", {vga_r, vga_g, vga_b}, mon_e.rgb);
                end
            end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                mon_e = sb.pop_front();
                check_val("pix_missing", rgb_valid, 1);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge SymClk);
            #1;
        end
    endtask

    task automatic send_pix(int x, int y);
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        pix_valid = 1'b1;
        sb.push_back('{rgb: model_rgb(x, y), due: cyc + 2});
        tick(1);
        pix_valid = 1'b0;
    endtask

    task automatic run_frame(logic [191:0] board, logic restart_mid);
        int pend[16];
        MatrixCopy  = board;
        frame_start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            pend[k] = calc_exp(int'(board[12 * k +: 12]));
            if (pend[k] == 15) bad_m = 1'b1;
        end
        send_pix(200, 120);
        frame_start = 1'b0;
        fcnt++;
        for (int c = 1; c <= 18; c++) begin
            check_val("scan_busy", scan_busy, (c <= 16) ? 1 : 0);
            if (c == 17) for (int k = 0; k < 16; k++) shown[k] = pend[k];
            if (c == 3) MatrixCopy = ~board;
            if (restart_mid && c == 5) begin
                frame_start = 1'b1;
                fcnt++;
            end
            if (c >= 15)         send_pix(200, 120);
            else if (c % 3 == 0) send_pix(270, 190);
            else if (c % 3 == 1) send_pix(445, 365);
            else                 send_pix(394, 120);
            frame_start = 1'b0;
        end
        tick(3);
        check_val("bad_tile", bad_tile, bad_m);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        fcnt++;
        tick(20);
    endtask

    task automatic probe_set();
        send_pix(200, 120);
        send_pix(270, 190);
        send_pix(445, 365);
        send_pix(100, 50);
        send_pix(192, 112);
        send_pix(256, 150);
        tick(3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset       = 1'b1;
        MatrixCopy  = '0;
        Done        = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        for (int k = 0; k < 16; k++) shown[k] = 0;
        tick(3);
        check_val("rst_rgb_valid", rgb_valid, 0);
        check_val("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check_val("rst_scan_busy", scan_busy, 0);
        check_val("rst_bad_tile", bad_tile, 0);
        Reset = 1'b0;
        tick(1);

        send_pix(200, 120);
        send_pix(394, 120);
        tick(3);
        check_val("idle_scan_busy", scan_busy, 0);
        check_val("idle_bad_tile", bad_tile, 0);

        // Tiles 0, 5, 15 with a second frame_start mid-scan and input changed mid-scan.
        brd = '0;
        brd[0 +: 12]   = 12'd2;
        brd[60 +: 12]  = 12'd16;
        brd[180 +: 12] = 12'd256;
        run_frame(brd, 1'b1);
        probe_set();

        // New board presented without frame_start must not show.
        MatrixCopy = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        probe_set();

        brd[36 +: 12] = 12'd6;
        run_frame(brd, 1'b0);
        send_pix(394, 120);
        probe_set();

        brd[36 +: 12] = 12'd4;
        run_frame(brd, 1'b0);
        send_pix(394, 120);
        tick(3);
        check_val("bad_sticky", bad_tile, 1);

        for (int k = 0; k < 16; k++) begin
            int e = int'($urandom_range(0, 11));
            brd[12 * k +: 12] = (e == 0) ? 12'd0 : 12'(1 << e);
        end
        run_frame(brd, 1'b0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                send_pix(192 + c * 64 + 32, 112 + r * 64 + 32);
        tick(3);

        MatrixCopy = brd;
        Done = 1'b1;
        for (int f = 0; f < 34; f++) begin
            pulse_fs();
            send_pix(200, 120);
            send_pix(192, 112);
            send_pix(100, 50);
            tick(3);
        end
        Done = 1'b0;
        for (int f = 0; f < 12; f++) begin
            pulse_fs();
            send_pix(270, 190);
            send_pix(256, 150);
            tick(3);
        end

        // Reset in the middle of a scan clears both banks and the sticky flag.
        brd[0 +: 12] = 12'd3;
        MatrixCopy = brd;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(6);
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
        for (int k = 0; k < 16; k++) shown[k] = 0;
        bad_m = 1'b0;
        fcnt  = 0;
        check_val("midrst_scan_busy", scan_busy, 0);
        check_val("midrst_bad_tile", bad_tile, bad_m);
        tick(20);
        send_pix(200, 120);
        send_pix(270, 190);
        send_pix(445, 365);
        tick(4);
        check_val("sb_leftover", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
